// File: rtl/decimal_to_priority_encoder_pkg.sv
// Shared widths and codes for the decimal-to-BCD priority encoder.
package decimal_to_priority_encoder_pkg;

  localparam int DEC_W  = 10;
  localparam int CODE_W = 4;

  localparam logic [CODE_W-1:0] CODE_NONE = 4'd0;

  // Combined encoder result: request-present flag plus the binary code.
  typedef struct packed {
    logic              any;
    logic [CODE_W-1:0] code;
  } enc_result_t;

endpackage

// File: rtl/decimal_to_priority_encoder_core.sv
// Combinational core: highest asserted decimal line -> binary code.
module decimal_priority_core
  import decimal_to_priority_encoder_pkg::*;
(
  input  logic [DEC_W-1:0]  d,
  output logic              any,
  output logic [CODE_W-1:0] code
);

  // Descending priority: the first matching pattern is the highest set bit,
  // so lower bits are don't-care.
  always_comb begin
    any  = 1'b1;
    code = CODE_NONE;
    casez (d)
      10'b1?????????: code = 4'd9;
      10'b01????????: code = 4'd8;
      10'b001???????: code = 4'd7;
      10'b0001??????: code = 4'd6;
      10'b00001?????: code = 4'd5;
      10'b000001????: code = 4'd4;
      10'b0000001???: code = 4'd3;
      10'b00000001??: code = 4'd2;
      10'b000000001?: code = 4'd1;
      10'b0000000001: code = 4'd0;
      default: begin
        any  = 1'b0;
        code = CODE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/decimal_to_priority_encoder.sv
// Registered 10-line decimal-to-BCD priority encoder with capture enable.
module decimal_to_priority_encoder
  import decimal_to_priority_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DEC_W-1:0]  d,
  output logic [CODE_W-1:0] q,
  output logic              valid
);

  enc_result_t enc;

  decimal_priority_core u_core (
    .d    (d),
    .any  (enc.any),
    .code (enc.code)
  );

  // Capture the encoded result when enabled; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= CODE_NONE;
      valid <= 1'b0;
    end else if (en) begin
      q     <= enc.code;
      valid <= enc.any;
    end
  end

endmodule

// File: tb/tb_decimal_to_priority_encoder.sv
// Scoreboard bench for decimal_to_priority_encoder with a highest-set-bit model.
module tb_decimal_to_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [9:0] d = '0;
  logic [3:0] q;
  logic       valid;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] q;
    logic       v;
    logic [9:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t stage;
  bit   stage_vld = 1'b0;

  // model output state
  logic [3:0] m_q = 4'd0;
  logic       m_v = 1'b0;

  decimal_to_priority_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (d),
    .q     (q),
    .valid (valid)
  );

  always #5 clk = ~clk;

  function automatic int highest_index(input logic [9:0] v);
    int n;
    n = int'(v);
    if (n == 0) return 0;
    return $clog2(n + 1) - 1;
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual == required) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, required);
  endtask

  // The DUT presents a new result at each capture edge; hand the staged
  // expectation to the scoreboard at that edge.
  always @(posedge clk) begin
    if (rst_n && stage_vld) begin
      exp_q.push_back(stage);
      stage_vld = 1'b0;
    end
  end

  // Monitor: compare the DUT output against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (q === e.q && valid === e.v) passed++;
      else $display("FAIL sb d=%b: got q=%0d valid=%0b, expected q=%0d valid=%0b",
                    e.d, q, valid, e.q, e.v);
      checks++;
      if (q <= 4'd9) passed++;
      else $display("FAIL q_range: got q=%0d, expected <= 9", q);
    end
  end

  task automatic drive(input logic en_v, input logic [9:0] d_v);
    @(posedge clk);
    #1;
    en = en_v;
    d  = d_v;
    if (en_v) begin
      m_q = 4'(highest_index(d_v));
      m_v = (d_v != 10'd0);
    end
    stage.q   = m_q;
    stage.v   = m_v;
    stage.d   = d_v;
    stage_vld = 1'b1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q.size() > 0 || stage_vld) && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    #1;
    checks++;
    if (exp_q.size() == 0 && !stage_vld) passed++;
    else $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
  endtask

  logic [9:0] sweep [11] = '{10'b0000000000, 10'b0000000001, 10'b0000000010,
                             10'b0000000101, 10'b0000001010, 10'b0000010101,
                             10'b0000101010, 10'b0001010101, 10'b0010101001,
                             10'b0101010101, 10'b1010101010};

  initial begin
    // Reset held with all requests asserted.
    rst_n = 1'b0;
    en    = 1'b1;
    d     = 10'b1111111111;
    #1;
    check("reset_q_immediate", int'(q), 0);
    check("reset_valid_immediate", int'(valid), 0);
    repeat (3) begin
      @(negedge clk);
      check("reset_q_hold", int'(q), 0);
      check("reset_valid_hold", int'(valid), 0);
    end
    rst_n = 1'b1;
    drive(1'b1, 10'b1111111111);
    drain();

    // Priority sweep.
    foreach (sweep[i]) drive(1'b1, sweep[i]);
    drain();

    // One-hot walk.
    for (int i = 0; i < 10; i++) drive(1'b1, 10'(1) << i);
    drain();

    // Hold with enable low.
    drive(1'b1, 10'b0000100000);
    repeat (3) drive(1'b0, 10'b1000000000);
    drive(1'b1, 10'b1000000000);
    drain();

    // Asynchronous reset between clock edges.
    drive(1'b1, 10'b0010000000);
    drain();
    @(posedge clk);
    #3;
    check("pre_async_q", int'(q), 7);
    rst_n = 1'b0;
    #1;
    check("async_reset_q", int'(q), 0);
    check("async_reset_valid", int'(valid), 0);
    #1;
    rst_n = 1'b1;
    m_q = 4'd0;
    m_v = 1'b0;

    // Exhaustive.
    for (int i = 0; i < 1024; i++) drive(1'b1, 10'(i));
    drain();

    // Random mix with enable toggling.
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 3) != 0), 10'($urandom_range(0, 1023)));
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/decimal_to_priority_encoder.md
# decimal_to_priority_encoder

Registered 10-line decimal-to-BCD priority encoder. It samples a 10-bit one-or-more-hot decimal request vector every clock and outputs the index (0–9) of the highest-numbered asserted line as a 4-bit binary code, with a valid flag. It sits behind keypad or request-line logic and feeds BCD consumers that need a single, stable digit per cycle.

## Interface
Parameters: none; widths are fixed at 10 inputs and 4 output bits.

- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- en  input  1  capture enable; when low, outputs hold their current values
- d  input  10  decimal request lines, active-high; d[i] requests digit i
- q  output  4  registered binary code of the highest asserted index, 0–9
- valid  output  1  registered flag; high when at least one bit of the captured d was set

## Operation
- Priority: the highest index wins. If d[i] = 1 and d[j] = 0 for all j > i, then the next q = i.
- Bits below the winning index are don't-care and never affect q.
- No request (d = 10'b0): q = 4'd0 and valid = 0. This output is distinguished from "digit 0 requested", which gives q = 4'd0 and valid = 1.
- Output encoding is plain binary, active-high, not inverted. Codes 10–15 are never produced.
- en = 0: q and valid hold their current values and d is ignored.
- X or Z on d does not need defined handling. Synthesis must not infer latches.

## Timing
- Reset (rst_n low, asynchronous): q = 4'd0 and valid = 0 immediately, independent of clk. The block stays in reset while rst_n is low.
- Release: the first capture occurs on the first rising clk edge with rst_n high and en high.
- Latency: 1 cycle. The d value present at rising edge N appears on q and valid after edge N.
- Throughput: one new code every cycle. There is no handshake and no backpressure.
- Simultaneous reset assertion and clock edge: reset wins.
- Changes on d between edges have no effect on the outputs.

## Structure
- Shared package holds:
  - DEC_W = 10
  - CODE_W = 4
  - CODE_NONE = 4'd0
- Sub-module decimal_priority_core: purely combinational. It maps d[9:0] to {any, code[3:0]} using a descending if/else priority chain or casez. The top level instantiates it and adds the enabled output register with asynchronous active-low reset.
- Total RTL, including the package and core, is about 120–150 lines.

## Test plan
- Reset: hold rst_n = 0 with d = 10'b1111111111 → q = 0 and valid = 0 immediately and throughout reset. Release rst_n, then one clock with en = 1 → q = 9 and valid = 1.
- Priority sweep, en = 1, one vector per clock, each checked one cycle later:
  - 10'b0000000000 → 0, valid 0
  - 10'b0000000001 → 0
  - 10'b0000000010 → 1
  - 10'b0000000101 → 2
  - 10'b0000001010 → 3
  - 10'b0000010101 → 4
  - 10'b0000101010 → 5
  - 10'b0001010101 → 6
  - 10'b0010101001 → 7
  - 10'b0101010101 → 8
  - 10'b1010101010 → 9
  - All vectors except the first give valid 1.
- One-hot walk: d = 1 << i for i = 0..9 → q = i and valid = 1 for each, with 1-cycle latency.
- Hold: capture d = 10'b0000100000, giving q = 5. Then set en = 0 and drive d = 10'b1000000000 for 3 cycles → q stays 5 and valid stays 1. Raise en → q = 9 on the next edge.
- Asynchronous reset mid-stream: while q = 7, pulse rst_n low between clock edges → q = 0 and valid = 0 without waiting for a clock edge.
- Exhaustive: all 1024 values of d against a reference model of the highest set bit → every q and valid matches, and no q value exceeds 9.
